// File: rtl/hyperbus_reg_async_src.sv
// Source side of the HyperBus register-bus CDC: turns one system-domain register
// request at a time into a 4-phase req/ack exchange and returns the response.
module hyperbus_reg_async_src #(
    parameter int RegAddrWidth = 32,
    parameter int RegDataWidth = 32,
    parameter int SyncStages   = 2,
    parameter int StallCycles  = 1024,
    localparam int RegReqWidth = RegAddrWidth + 1 + RegDataWidth + RegDataWidth / 8 + 1,
    localparam int RegRspWidth = RegDataWidth + 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [RegReqWidth-1:0] reg_req_i,
    output logic [RegRspWidth-1:0] reg_rsp_o,
    output logic                   async_reg_req_req_o,
    input  logic                   async_reg_req_ack_i,
    output logic [RegReqWidth-1:0] async_reg_req_data_o,
    input  logic                   async_reg_rsp_req_i,
    output logic                   async_reg_rsp_ack_o,
    input  logic [RegRspWidth-1:0] async_reg_rsp_data_i,
    output logic                   busy_o,
    output logic                   stall_o
);

    typedef enum logic [2:0] {
        IDLE,
        REQ_HI,
        REQ_LO,
        RSP_WAIT,
        RSP_ACK,
        DONE
    } state_t;

    localparam logic [31:0] StallLimit = 32'(StallCycles);

    state_t                  state;
    logic [SyncStages-1:0]   ack_sync;
    logic [SyncStages-1:0]   rsp_req_sync;
    logic                    ack_s;
    logic                    rsp_req_s;
    logic                    req_q;
    logic                    rsp_ack_q;
    logic                    busy_q;
    logic                    ready_q;
    logic                    stall_q;
    logic [RegReqWidth-1:0]  req_data;
    logic [RegDataWidth-1:0] rsp_rdata;
    logic                    rsp_error;
    logic [31:0]             wait_cnt;
    logic                    hold;
    logic                    unused_rsp_ready;

    // The destination's own ready field carries no meaning on this side.
    assign unused_rsp_ready = async_reg_rsp_data_i[0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_sync     <= '0;
            rsp_req_sync <= '0;
        end else begin
            ack_sync     <= {ack_sync[SyncStages-2:0], async_reg_req_ack_i};
            rsp_req_sync <= {rsp_req_sync[SyncStages-2:0], async_reg_rsp_req_i};
        end
    end

    assign ack_s     = ack_sync[SyncStages-1];
    assign rsp_req_s = rsp_req_sync[SyncStages-1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            req_q     <= 1'b0;
            rsp_ack_q <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
            req_data  <= '0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (reg_req_i[0]) begin
                        req_data <= {reg_req_i[RegReqWidth-1:1], 1'b1};
                        req_q    <= 1'b1;
                        busy_q   <= 1'b1;
                        state    <= REQ_HI;
                    end
                end
                REQ_HI: begin
                    if (ack_s) begin
                        req_q <= 1'b0;
                        state <= REQ_LO;
                    end
                end
                REQ_LO: begin
                    if (!ack_s) begin
                        state <= RSP_WAIT;
                    end
                end
                RSP_WAIT: begin
                    // Payload has been stable for SyncStages cycles by the time rsp_req_s is seen.
                    if (rsp_req_s) begin
                        rsp_rdata <= async_reg_rsp_data_i[RegRspWidth-1:2];
                        rsp_error <= async_reg_rsp_data_i[1];
                        rsp_ack_q <= 1'b1;
                        state     <= RSP_ACK;
                    end
                end
                RSP_ACK: begin
                    if (!rsp_req_s) begin
                        rsp_ack_q <= 1'b0;
                        ready_q   <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    req_q     <= 1'b0;
                    rsp_ack_q <= 1'b0;
                    busy_q    <= 1'b0;
                    ready_q   <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // High on a cycle where a handshake state waits without moving on.
    always_comb begin
        hold = 1'b0;
        case (state)
            REQ_HI:   hold = !ack_s;
            REQ_LO:   hold = ack_s;
            RSP_WAIT: hold = !rsp_req_s;
            RSP_ACK:  hold = rsp_req_s;
            default:  hold = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wait_cnt <= '0;
            stall_q  <= 1'b0;
        end else begin
            if (hold) begin
                wait_cnt <= wait_cnt + 32'd1;
                if ((StallCycles != 0) && (wait_cnt + 32'd1 == StallLimit)) begin
                    stall_q <= 1'b1;
                end
            end else begin
                wait_cnt <= '0;
            end
            if ((state == RSP_ACK) && !rsp_req_s) begin
                stall_q <= 1'b0;
            end
        end
    end

    assign reg_rsp_o            = {rsp_rdata, rsp_error, ready_q};
    assign async_reg_req_req_o  = req_q;
    assign async_reg_req_data_o = req_data;
    assign async_reg_rsp_ack_o  = rsp_ack_q;
    assign busy_o               = busy_q;
    assign stall_o              = stall_q;

endmodule

// File: tb/tb_hyperbus_reg_async_src.sv
// Directed bench for hyperbus_reg_async_src with a negedge-clocked destination model
// that can delay, withhold or freeze its side of the 4-phase handshake.
module tb_hyperbus_reg_async_src;

    localparam int ReqW = 70;
    localparam int RspW = 34;

    logic            clk_i;
    logic            rst_i;
    logic [ReqW-1:0] reg_req_i;
    logic [RspW-1:0] reg_rsp_o;
    logic            req_o;
    logic            dst_ack;
    logic [ReqW-1:0] req_data_o;
    logic            dst_rsp_req;
    logic            rsp_ack_o;
    logic [RspW-1:0] dst_rsp_data;
    logic            busy_o;
    logic            stall_o;

    int checks;
    int errors;
    int req_rises;

    int          ack_delay;
    logic        hold_ack;
    logic        hold_rsp;
    logic [31:0] dst_rdata;
    logic        dst_error;
    int          dst_phase;
    int          dst_cnt;

    hyperbus_reg_async_src #(
        .RegAddrWidth(32),
        .RegDataWidth(32),
        .SyncStages  (2),
        .StallCycles (16)
    ) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .reg_req_i           (reg_req_i),
        .reg_rsp_o           (reg_rsp_o),
        .async_reg_req_req_o (req_o),
        .async_reg_req_ack_i (dst_ack),
        .async_reg_req_data_o(req_data_o),
        .async_reg_rsp_req_i (dst_rsp_req),
        .async_reg_rsp_ack_o (rsp_ack_o),
        .async_reg_rsp_data_i(dst_rsp_data),
        .busy_o              (busy_o),
        .stall_o             (stall_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial req_rises = 0;
    always @(posedge req_o) req_rises <= req_rises + 1;

    // Reacting on the falling edge behaves like a zero-latency destination.
    always @(negedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dst_ack      <= 1'b0;
            dst_rsp_req  <= 1'b0;
            dst_rsp_data <= '0;
            dst_phase    <= 0;
            dst_cnt      <= 0;
        end else begin
            case (dst_phase)
                0: if (req_o) begin
                    if (!hold_ack && dst_cnt >= ack_delay) begin
                        dst_ack   <= 1'b1;
                        dst_phase <= 1;
                        dst_cnt   <= 0;
                    end else begin
                        dst_cnt <= dst_cnt + 1;
                    end
                end
                1: if (!req_o) begin
                    dst_ack      <= 1'b0;
                    dst_rsp_data <= {dst_rdata, dst_error, 1'b0};
                    dst_rsp_req  <= 1'b1;
                    dst_phase    <= 2;
                end
                2: if (rsp_ack_o && !hold_rsp) begin
                    dst_rsp_req <= 1'b0;
                    dst_phase   <= 0;
                end
                default: dst_phase <= 0;
            endcase
        end
    end

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive a request and return just after the edge that accepts it.
    task automatic applyStimulus(input logic [ReqW-1:0] req);
        logic seen;
        seen = 1'b0;
        reg_req_i = req;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(posedge clk_i);
            #1;
            if (busy_o) seen = 1'b1;
        end
        checkOutput("accepted", seen, 1'b1);
    endtask

    task automatic waitReady(output int cycles);
        logic seen;
        seen = 1'b0;
        cycles = 0;
        for (int i = 1; i <= 200 && !seen; i++) begin
            @(posedge clk_i);
            #1;
            if (reg_rsp_o[0]) begin
                seen = 1'b1;
                cycles = i;
            end
        end
        reg_req_i = '0;
        checkOutput("ready_seen", seen, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [ReqW-1:0] req_a;
        logic [ReqW-1:0] req_b;
        int lat;
        int base;

        checks    = 0;
        errors    = 0;
        rst_i     = 1'b1;
        reg_req_i = '0;
        ack_delay = 0;
        hold_ack  = 1'b0;
        hold_rsp  = 1'b0;
        dst_rdata = '0;
        dst_error = 1'b0;

        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("rst_req", req_o, 1'b0);
        checkOutput("rst_rsp_ack", rsp_ack_o, 1'b0);
        checkOutput("rst_busy", busy_o, 1'b0);
        checkOutput("rst_stall", stall_o, 1'b0);
        checkOutput("rst_rsp", reg_rsp_o, '0);
        checkOutput("rst_data", req_data_o, '0);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // Write, destination acks 3 cycles late.
        ack_delay = 3;
        dst_rdata = 32'h0;
        dst_error = 1'b0;
        req_a = {32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 1'b1};
        applyStimulus(req_a);
        checkOutput("wr_req_hi", req_o, 1'b1);
        checkOutput("wr_data", req_data_o, req_a);
        waitReady(lat);
        checkOutput("wr_latency", lat, 13);
        checkOutput("wr_error", reg_rsp_o[1], 1'b0);
        checkOutput("wr_stall", stall_o, 1'b0);
        @(posedge clk_i);
        #1;
        checkOutput("wr_ready_pulse", reg_rsp_o[0], 1'b0);
        checkOutput("wr_busy_after", busy_o, 1'b0);

        // Read returning an error.
        ack_delay = 1;
        dst_rdata = 32'h12345678;
        dst_error = 1'b1;
        applyStimulus({32'h04, 1'b0, 32'h0, 4'h0, 1'b1});
        waitReady(lat);
        checkOutput("rd_rsp", reg_rsp_o, {32'h12345678, 1'b1, 1'b1});
        @(posedge clk_i);
        #1;
        checkOutput("rd_rsp_idle", reg_rsp_o, {32'h12345678, 1'b1, 1'b0});
        checkOutput("rd_busy_after", busy_o, 1'b0);

        // Back-to-back: second request appears while ready is high.
        ack_delay = 0;
        dst_rdata = 32'hA5A5A5A5;
        dst_error = 1'b0;
        base = req_rises;
        req_a = {32'h20, 1'b1, 32'h01020304, 4'h3, 1'b1};
        req_b = {32'h08, 1'b0, 32'h0, 4'h0, 1'b1};
        applyStimulus(req_a);
        waitReady(lat);
        reg_req_i = req_b;
        @(posedge clk_i);
        #1;
        checkOutput("b2b_idle_gap", busy_o, 1'b0);
        applyStimulus(req_b);
        checkOutput("b2b_data2", req_data_o, req_b);
        waitReady(lat);
        checkOutput("b2b_rsp2", reg_rsp_o, {32'hA5A5A5A5, 1'b0, 1'b1});
        repeat (6) @(posedge clk_i);
        #1;
        checkOutput("b2b_rises", req_rises - base, 2);
        checkOutput("b2b_busy_end", busy_o, 1'b0);

        // Minimum latency with a zero-latency destination.
        applyStimulus({32'h0C, 1'b0, 32'h0, 4'h0, 1'b1});
        waitReady(lat);
        checkOutput("min_latency", lat, 10);

        // Watchdog: ack withheld until stall is flagged.
        hold_ack  = 1'b1;
        dst_rdata = 32'h0BADF00D;
        applyStimulus({32'h14, 1'b0, 32'h0, 4'h0, 1'b1});
        repeat (15) @(posedge clk_i);
        #1;
        checkOutput("wd_stall_15", stall_o, 1'b0);
        @(posedge clk_i);
        #1;
        checkOutput("wd_stall_16", stall_o, 1'b1);
        checkOutput("wd_req_held", req_o, 1'b1);
        repeat (5) @(posedge clk_i);
        #1;
        checkOutput("wd_sticky", stall_o, 1'b1);
        hold_ack = 1'b0;
        waitReady(lat);
        checkOutput("wd_stall_clear", stall_o, 1'b0);
        checkOutput("wd_rsp", reg_rsp_o, {32'h0BADF00D, 1'b0, 1'b1});

        // Reset while parked in RSP_ACK.
        hold_rsp  = 1'b1;
        dst_rdata = 32'h55AA55AA;
        applyStimulus({32'h18, 1'b0, 32'h0, 4'h0, 1'b1});
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 50 && !seen; i++) begin
                @(posedge clk_i);
                #1;
                if (rsp_ack_o) seen = 1'b1;
            end
            checkOutput("mid_rsp_ack_seen", seen, 1'b1);
        end
        #1;
        rst_i = 1'b1;
        reg_req_i = '0;
        #1;
        checkOutput("mid_req", req_o, 1'b0);
        checkOutput("mid_rsp_ack", rsp_ack_o, 1'b0);
        checkOutput("mid_busy", busy_o, 1'b0);
        checkOutput("mid_rsp", reg_rsp_o, '0);
        hold_rsp = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        dst_rdata = 32'hCAFEF00D;
        dst_error = 1'b0;
        applyStimulus({32'h1C, 1'b0, 32'h0, 4'h0, 1'b1});
        waitReady(lat);
        checkOutput("post_rst_rsp", reg_rsp_o, {32'hCAFEF00D, 1'b0, 1'b1});
        checkOutput("post_rst_latency", lat, 10);
        @(posedge clk_i);
        #1;
        checkOutput("post_rst_busy", busy_o, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hyperbus_reg_async_src.md
Name: hyperbus_reg_async_src

Overview:
- SoC-side source half of the HyperBus configuration register-bus clock-domain crossing.
- Accepts register-bus requests in the system clock domain and serialises each one onto the 4-phase request/acknowledge bundle consumed by the HyperBus macro's `async_reg_req_*` / `async_reg_rsp_*` ports.
- Returns the macro's response to the requester.
- Exactly one transaction is in flight at a time. Incoming handshake levels pass through internal synchronisers.

Parameters:
- RegAddrWidth, 32, register-bus address width
- RegDataWidth, 32, register-bus data width; strobe width is RegDataWidth/8
- SyncStages, 2, flip-flop stages on each incoming async level (ack, rsp_req); legal range 2..4
- StallCycles, 1024, wait-cycle count before `stall_o` asserts; 0 disables the watchdog
- RegReqWidth (local), RegAddrWidth+1+RegDataWidth+RegDataWidth/8+1
- RegRspWidth (local), RegDataWidth+2

Ports:
- clk_i  in  1  system clock; the only clock
- rst_i  in  1  reset, asynchronous, active-high
- reg_req_i  in  RegReqWidth  packed request, MSB..LSB: {addr, write, wdata, wstrb, valid}
- reg_rsp_o  out  RegRspWidth  packed response, MSB..LSB: {rdata, error, ready}
- async_reg_req_req_o  out  1  4-phase request level
- async_reg_req_ack_i  in  1  4-phase request acknowledge (asynchronous)
- async_reg_req_data_o  out  RegReqWidth  latched request; stable whenever req_o=1
- async_reg_rsp_req_i  in  1  4-phase response request (asynchronous)
- async_reg_rsp_ack_o  out  1  4-phase response acknowledge
- async_reg_rsp_data_i  in  RegRspWidth  response payload; valid while rsp_req_i=1
- busy_o  out  1  high whenever the FSM is not IDLE
- stall_o  out  1  sticky watchdog flag

Behaviour:
- Reset values: all outputs are 0, FSM is in IDLE, synchronisers are cleared, data latch is 0. Reset applies asynchronously; deassertion is used synchronously.
- ack_s and rsp_req_s are the incoming levels after SyncStages flops. All decisions use only the synchronised levels; raw inputs are never used in logic.
- IDLE:
  - If the request's valid bit = 1, latch reg_req_i into the data register with the valid bit forced to 1, then go to REQ_HI.
  - reg_rsp_o.ready = 0 throughout IDLE.
- REQ_HI: req_o=1, data held. Go to REQ_LO when ack_s=1.
- REQ_LO: req_o=0. Go to RSP_WAIT when ack_s=0.
- RSP_WAIT:
  - When rsp_req_s=1, capture async_reg_rsp_data_i into the response register and go to RSP_ACK.
  - The capture is safe because the payload is stable for at least SyncStages cycles before rsp_req_s rises.
- RSP_ACK: rsp_ack_o=1. Go to DONE when rsp_req_s=0.
- DONE:
  - rsp_ack_o=0.
  - reg_rsp_o = {captured rdata, captured error, 1} for exactly one cycle, then IDLE.
  - The ready bit is forced to 1 regardless of the captured ready field.
- reg_rsp_o.rdata and reg_rsp_o.error hold the last captured values until the next capture; ready is high only in DONE.
- Request data never changes outside IDLE; a new reg_req_i during non-IDLE states is ignored (the requester holds valid until ready).
- The earliest re-accept is the cycle after DONE. A requester that drops valid on ready is therefore never double-accepted.
- Minimum latency, valid to ready: 4*SyncStages + 2 cycles, with an ideal destination of zero added latency.
- Watchdog:
  - A 32-bit counter increments each cycle spent in REQ_HI, REQ_LO, RSP_WAIT or RSP_ACK without a state change; it clears on any transition.
  - When the counter reaches StallCycles (and StallCycles≠0), stall_o is set.
  - stall_o clears only on the DONE cycle or on reset. It never aborts the handshake.
- busy_o = (state != IDLE).
- Reset mid-operation: all levels drop immediately. The destination side shares this reset through the SoC reset tree; no recovery sequence exists in this block.
- Glitch-free drive: req_o and rsp_ack_o come directly from flops.

Test Plan:
- Write: addr=0x10, wdata=0xDEADBEEF, wstrb=0xF, write=1; destination model acks after 3 cycles and responds with error=0 -> async_reg_req_data_o matches the packed request while req_o=1, ready pulses exactly 1 cycle, error=0, busy_o low afterwards.
- Read: addr=0x04; destination returns rdata=0x12345678, error=1 -> reg_rsp_o = {0x12345678, 1, 1} for one cycle; rdata remains 0x12345678 in IDLE.
- Back-to-back: requester holds valid, then issues a second request (addr=0x08) on the cycle after ready -> exactly two req_o rising edges, second data latched correctly, no duplicate transaction.
- Minimum latency, SyncStages=2, zero-latency destination -> ready exactly 10 cycles after valid is accepted.
- Watchdog, StallCycles=16: destination never acks -> stall_o rises exactly on the 16th stall cycle and req_o stays 1; ack later released -> transaction completes and stall_o clears on DONE.
- Reset while in RSP_ACK -> req_o, rsp_ack_o, busy_o, ready all 0 in the same cycle; after release, a new read completes normally.
